// File: rtl/lcd_write_arbiter_if.sv
// rtl/lcd_write_arbiter_if.sv - request and LCD bus bundle for lcd_write_arbiter
interface lcd_write_arbiter_if;
  logic       REQ0, REQ1;
  logic       ROW0, ROW1;
  logic [3:0] COL0, COL1;
  logic [7:0] CHR0, CHR1;
  logic       ACK0, ACK1;
  logic       BUSY;
  logic       LCD_E, LCD_RS, LCD_RW;
  logic [7:0] LCD_DATA;

  modport slave (
    input  REQ0, REQ1, ROW0, ROW1, COL0, COL1, CHR0, CHR1,
    output ACK0, ACK1, BUSY, LCD_E, LCD_RS, LCD_RW, LCD_DATA
  );

  modport master (
    output REQ0, REQ1, ROW0, ROW1, COL0, COL1, CHR0, CHR1,
    input  ACK0, ACK1, BUSY, LCD_E, LCD_RS, LCD_RW, LCD_DATA
  );
endinterface

// File: rtl/lcd_write_arbiter.sv
// rtl/lcd_write_arbiter.sv - LCD init sequencer and two-requester character write arbiter
// Optional round-robin arbitration when LCD_ARB_RR_EN is defined; fixed priority (REQ0) otherwise.
module lcd_write_arbiter #(
  parameter int INIT_WAIT = 70,
  parameter int CMD_HOLD  = 30,
  parameter int CHAR_HOLD = 20,
  parameter int CLR_HOLD  = 200
) (
  input logic               CLK,
  input logic               RST,
  lcd_write_arbiter_if.slave bus
);

  localparam int SW = 16;

  typedef enum logic [2:0] {
    S_WAIT, S_FSET, S_DISP, S_ENTRY, S_CLEAR, S_IDLE, S_ADDR, S_CHAR
  } state_t;

  state_t        state, nxt_state;
  logic [SW-1:0] scnt, nxt_scnt;
  logic          cap_row;
  logic [3:0]    cap_col;
  logic [7:0]    cap_chr;
  logic          grant0, grant1;
  logic          sel_row;
  logic [3:0]    sel_col;
  logic [7:0]    sel_chr;
  logic [7:0]    nxt_data;
  logic          nxt_e;

  function automatic logic [SW-1:0] slot_len(input state_t s);
    case (s)
      S_WAIT:  slot_len = SW'(INIT_WAIT);
      S_CLEAR: slot_len = SW'(CLR_HOLD);
      S_CHAR:  slot_len = SW'(CHAR_HOLD);
      default: slot_len = SW'(CMD_HOLD);
    endcase
  endfunction

`ifdef LCD_ARB_RR_EN
  logic last;

  // On a tie the requester that was not granted last time wins.
  always_comb begin
    grant0 = bus.REQ0 & (~bus.REQ1 | last);
    grant1 = bus.REQ1 & (~bus.REQ0 | ~last);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      last <= 1'b1;
    else if (state == S_IDLE && (grant0 || grant1))
      last <= grant1;
  end
`else
  assign grant0 = bus.REQ0;
  assign grant1 = bus.REQ1 & ~bus.REQ0;
`endif

  always_comb begin
    nxt_state = state;
    nxt_scnt  = scnt + 1'b1;
    if (state == S_IDLE) begin
      nxt_scnt = '0;
      if (grant0 || grant1)
        nxt_state = S_ADDR;
    end else if (scnt == slot_len(state) - 1'b1) begin
      nxt_scnt = '0;
      case (state)
        S_WAIT:  nxt_state = S_FSET;
        S_FSET:  nxt_state = S_DISP;
        S_DISP:  nxt_state = S_ENTRY;
        S_ENTRY: nxt_state = S_CLEAR;
        S_ADDR:  nxt_state = S_CHAR;
        default: nxt_state = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so the registered bus lines up with the slot start.
  always_comb begin
    sel_row = (state == S_IDLE) ? (grant1 ? bus.ROW1 : bus.ROW0) : cap_row;
    sel_col = (state == S_IDLE) ? (grant1 ? bus.COL1 : bus.COL0) : cap_col;
    sel_chr = grant1 ? bus.CHR1 : bus.CHR0;
    case (nxt_state)
      S_FSET:  nxt_data = 8'h3C;
      S_DISP:  nxt_data = 8'h0C;
      S_ENTRY: nxt_data = 8'h06;
      S_CLEAR: nxt_data = 8'h01;
      S_ADDR:  nxt_data = {1'b1, sel_row, 2'b00, sel_col};
      S_CHAR:  nxt_data = cap_chr;
      default: nxt_data = 8'h00;
    endcase
    nxt_e = (nxt_state != S_WAIT) && (nxt_state != S_IDLE) &&
            (nxt_scnt != '0) && (nxt_scnt <= (slot_len(nxt_state) >> 1));
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state        <= S_WAIT;
      scnt         <= '0;
      cap_row      <= 1'b0;
      cap_col      <= 4'h0;
      cap_chr      <= 8'h00;
      bus.ACK0     <= 1'b0;
      bus.ACK1     <= 1'b0;
      bus.BUSY     <= 1'b1;
      bus.LCD_E    <= 1'b0;
      bus.LCD_RS   <= 1'b0;
      bus.LCD_DATA <= 8'h00;
    end else begin
      state <= nxt_state;
      scnt  <= nxt_scnt;
      if (state == S_IDLE && nxt_state == S_ADDR) begin
        cap_row <= sel_row;
        cap_col <= sel_col;
        cap_chr <= sel_chr;
      end
      bus.ACK0     <= (state == S_IDLE) && grant0;
      bus.ACK1     <= (state == S_IDLE) && grant1;
      bus.BUSY     <= (nxt_state != S_IDLE);
      bus.LCD_E    <= nxt_e;
      bus.LCD_RS   <= (nxt_state == S_CHAR);
      bus.LCD_DATA <= nxt_data;
    end
  end

  assign bus.LCD_RW = 1'b0;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// tb/tb_lcd_write_arbiter.sv - scoreboard bench for lcd_write_arbiter with a timeline reference model
module tb_lcd_write_arbiter;
  localparam int INIT_WAIT = 70;
  localparam int CMD_HOLD  = 30;
  localparam int CHAR_HOLD = 20;
  localparam int CLR_HOLD  = 200;
  localparam int INIT_CYC  = INIT_WAIT + 3 * CMD_HOLD + CLR_HOLD;
  localparam int NTRANS    = 6;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  lcd_write_arbiter_if bus();

  lcd_write_arbiter #(
    .INIT_WAIT(INIT_WAIT), .CMD_HOLD(CMD_HOLD), .CHAR_HOLD(CHAR_HOLD), .CLR_HOLD(CLR_HOLD)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         id;
    int         cyc;
    logic [7:0] addr;
    logic [7:0] chr;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   idle_from = INIT_CYC + 1;
  exp_t exp_q[$];
`ifdef LCD_ARB_RR_EN
  bit   last_g = 1'b1;
`endif

  bit          mon_active = 1'b0;
  int          mon_t0 = 0;
  int          mon_off = 0;
  logic [7:0]  mon_addr = 8'h00;
  logic [7:0]  mon_chr = 8'h00;
  logic [11:0] exp_bus;
  exp_t        e_pop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic got_ack(input int id);
    return (id == 0) ? bus.ACK0 : bus.ACK1;
  endfunction

  task automatic drive(input int id, input logic q, input logic r, input logic [3:0] c, input logic [7:0] ch);
    if (id == 0) begin
      bus.REQ0 = q; bus.ROW0 = r; bus.COL0 = c; bus.CHR0 = ch;
    end else begin
      bus.REQ1 = q; bus.ROW1 = r; bus.COL1 = c; bus.CHR1 = ch;
    end
  endtask

  task automatic drop_req(input int id);
    if (id == 0) bus.REQ0 = 1'b0;
    else         bus.REQ1 = 1'b0;
  endtask

  // Reference model: one grant per free slot, the arbiter is free from INIT_CYC+1 and again 51 cycles after each grant.
  initial forever begin
    @(posedge CLK or negedge RST);
    if (!RST) begin
      cyc = 0;
      idle_from = INIT_CYC + 1;
      exp_q.delete();
`ifdef LCD_ARB_RR_EN
      last_g = 1'b1;
`endif
    end else begin
      cyc++;
      if (cyc >= idle_from && (bus.REQ0 || bus.REQ1)) begin
        exp_t e;
        int   w;
        if (bus.REQ0 && bus.REQ1) begin
`ifdef LCD_ARB_RR_EN
          w = last_g ? 0 : 1;
`else
          w = 0;
`endif
        end else begin
          w = bus.REQ0 ? 0 : 1;
        end
`ifdef LCD_ARB_RR_EN
        last_g = (w == 1);
`endif
        e.id   = w;
        e.cyc  = cyc;
        e.addr = (w == 0) ? (8'h80 | (8'(bus.ROW0) << 6) | 8'(bus.COL0))
                          : (8'h80 | (8'(bus.ROW1) << 6) | 8'(bus.COL1));
        e.chr  = (w == 0) ? bus.CHR0 : bus.CHR1;
        exp_q.push_back(e);
        idle_from = cyc + CMD_HOLD + CHAR_HOLD + 1;
      end
    end
  end

  // Monitor: pops on every ACK and then follows the address and character slots.
  initial forever begin
    @(negedge CLK or negedge RST);
    if (!RST) begin
      mon_active = 1'b0;
    end else begin
      if (bus.ACK0 || bus.ACK1) begin
        chk("ack_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e_pop = exp_q.pop_front();
          chk($sformatf("ack_req%0d_cycle_and_id", e_pop.id),
              {cyc[29:0], bus.ACK0, bus.ACK1},
              {e_pop.cyc[29:0], e_pop.id == 0, e_pop.id == 1});
          mon_active = 1'b1;
          mon_t0     = cyc;
          mon_addr   = e_pop.addr;
          mon_chr    = e_pop.chr;
        end
      end
      if (mon_active) begin
        mon_off = cyc - mon_t0;
        if (mon_off < CMD_HOLD) begin
          exp_bus = {1'b1, 1'b0, 1'b0, (mon_off >= 1 && mon_off <= CMD_HOLD / 2), mon_addr};
          chk("addr_slot_bus", 32'({bus.BUSY, bus.LCD_RS, bus.LCD_RW, bus.LCD_E, bus.LCD_DATA}), 32'(exp_bus));
        end else if (mon_off < CMD_HOLD + CHAR_HOLD) begin
          exp_bus = {1'b1, 1'b1, 1'b0,
                     (mon_off - CMD_HOLD >= 1 && mon_off - CMD_HOLD <= CHAR_HOLD / 2), mon_chr};
          chk("char_slot_bus", 32'({bus.BUSY, bus.LCD_RS, bus.LCD_RW, bus.LCD_E, bus.LCD_DATA}), 32'(exp_bus));
        end else begin
          chk("idle_return", 32'({bus.BUSY, bus.LCD_E}), 32'd0);
          mon_active = 1'b0;
        end
      end
    end
  end

  task automatic run_req(input int id);
    for (int n = 0; n < NTRANS; n++) begin
      int         w;
      int         gap;
      logic       r;
      logic [3:0] c;
      logic [7:0] ch;
      if (n == 0) begin
        r  = id[0];
        c  = (id == 0) ? 4'd5 : 4'd15;
        ch = (id == 0) ? 8'h41 : 8'h50;
      end else begin
        r  = 1'($urandom_range(0, 1));
        c  = 4'($urandom_range(0, 15));
        ch = 8'($urandom_range(32, 126));
      end
      drive(id, 1'b1, r, c, ch);
      w = 0;
      do begin
        @(negedge CLK);
        w++;
      end while (!got_ack(id) && w < 5000);
      chk($sformatf("req%0d_ack_within_bound", id), 32'(got_ack(id)), 32'd1);
      gap = $urandom_range(0, 3);
      if (gap != 0 || n == NTRANS - 1) begin
        drop_req(id);
        repeat (gap * 9) @(negedge CLK);
      end
    end
  endtask

  task automatic rst_pulse();
    int w;
    w = 0;
    do begin
      @(negedge CLK);
      w++;
    end while (!(bus.ACK0 || bus.ACK1) && w < 5000);
    repeat (5) @(negedge CLK);
    #2 RST = 1'b0;
    #1 chk("async_reset_outputs",
           32'({bus.BUSY, bus.ACK0, bus.ACK1, bus.LCD_E, bus.LCD_RS, bus.LCD_RW, bus.LCD_DATA}),
           32'h2000);
    #1 RST = 1'b1;
  endtask

  initial begin
    int   e_rise;
    int   e_high;
    int   rw_bad;
    logic pe;
    e_rise = 0; e_high = 0; rw_bad = 0; pe = 1'b0;
    drive(0, 1'b0, 1'b0, 4'h0, 8'h00);
    drive(1, 1'b0, 1'b0, 4'h0, 8'h00);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    chk("reset_state",
        32'({bus.BUSY, bus.ACK0, bus.ACK1, bus.LCD_E, bus.LCD_RS, bus.LCD_RW, bus.LCD_DATA}),
        32'h2000);
    RST = 1'b1;

    while (cyc < INIT_CYC) begin
      @(negedge CLK);
      if (bus.LCD_E && !pe) e_rise++;
      if (bus.LCD_E) e_high++;
      if (bus.LCD_RW !== 1'b0) rw_bad++;
      pe = bus.LCD_E;
      if (cyc == INIT_WAIT - 1)
        chk("wait_quiet", 32'({bus.LCD_E, bus.LCD_RS, bus.LCD_DATA}), 32'd0);
      if (cyc == INIT_WAIT)
        chk("fset_byte", 32'({bus.LCD_RS, bus.LCD_DATA}), 32'h03C);
      if (cyc == INIT_WAIT + CMD_HOLD)
        chk("disp_byte", 32'({bus.LCD_RS, bus.LCD_DATA}), 32'h00C);
      if (cyc == INIT_WAIT + 2 * CMD_HOLD)
        chk("entry_byte", 32'({bus.LCD_RS, bus.LCD_DATA}), 32'h006);
      if (cyc == INIT_WAIT + 3 * CMD_HOLD)
        chk("clear_byte", 32'({bus.LCD_RS, bus.LCD_DATA}), 32'h001);
      if (cyc == INIT_CYC - 1)
        chk("busy_before_idle", 32'(bus.BUSY), 32'd1);
      if (cyc == INIT_CYC)
        chk("busy_falls", 32'(bus.BUSY), 32'd0);
    end
    chk("init_e_pulses", 32'(e_rise), 32'd4);
    chk("init_e_high_cycles", 32'(e_high), 32'(3 * (CMD_HOLD / 2) + CLR_HOLD / 2));
    chk("init_rw_low", 32'(rw_bad), 32'd0);

    fork
      run_req(0);
      run_req(1);
      rst_pulse();
    join

    repeat (60) @(negedge CLK);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    chk("monitor_idle", 32'(mon_active), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time (checks %0d)", checks);
    $fatal(1, "watchdog");
  end

endmodule
